// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared counter encodings and update helper for the branch predictor
//
// Purpose: 2-bit saturating counter encodings, reset/allocation values and the
// saturating step function used when training a hitting entry.
// Ports: none (package).
package bp_pkg;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  localparam ctr_e CTR_RESET    = CTR_WNT;
  localparam ctr_e CTR_ALLOC_T  = CTR_WT;
  localparam ctr_e CTR_ALLOC_NT = CTR_WNT;

  // Move one step toward the actual outcome, holding at the strong ends.
  function automatic ctr_e ctr_step(input ctr_e c, input logic taken);
    ctr_step = c;
    case (c)
      CTR_SNT: ctr_step = taken ? CTR_WNT : CTR_SNT;
      CTR_WNT: ctr_step = taken ? CTR_WT  : CTR_SNT;
      CTR_WT:  ctr_step = taken ? CTR_ST  : CTR_WNT;
      CTR_ST:  ctr_step = taken ? CTR_ST  : CTR_WT;
      default: ctr_step = c;
    endcase
  endfunction

endpackage

// File: rtl/bht_table.sv
// rtl/bht_table.sv - flop-based branch history table storage
//
// Purpose: valid/tag/counter arrays with a combinational lookup port and a
// synchronous write port. The write port also presents the current contents
// of the entry it addresses so the owner can do a read-modify-write.
// Ports:
//   clk_i, rst_i                          clock, synchronous active-high reset
//   rd_idx_i -> rd_valid_o/rd_tag_o/rd_ctr_o      lookup port (combinational)
//   wr_en_i, wr_idx_i, wr_tag_i, wr_ctr_i          write port (sets valid)
//   wr_old_valid_o/wr_old_tag_o/wr_old_ctr_o       pre-write entry at wr_idx_i
module bht_table
  import bp_pkg::*;
#(
  parameter int ENTRIES    = 32,
  parameter int INDEX_BITS = 5,
  parameter int TAG_BITS   = 25
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [INDEX_BITS-1:0] rd_idx_i,
  output logic                  rd_valid_o,
  output logic [TAG_BITS-1:0]   rd_tag_o,
  output ctr_e                  rd_ctr_o,
  input  logic                  wr_en_i,
  input  logic [INDEX_BITS-1:0] wr_idx_i,
  input  logic [TAG_BITS-1:0]   wr_tag_i,
  input  ctr_e                  wr_ctr_i,
  output logic                  wr_old_valid_o,
  output logic [TAG_BITS-1:0]   wr_old_tag_o,
  output ctr_e                  wr_old_ctr_o
);

  logic                valid_q [ENTRIES];
  logic [TAG_BITS-1:0] tag_q   [ENTRIES];
  ctr_e                ctr_q   [ENTRIES];

  assign rd_valid_o     = valid_q[rd_idx_i];
  assign rd_tag_o       = tag_q[rd_idx_i];
  assign rd_ctr_o       = ctr_q[rd_idx_i];
  assign wr_old_valid_o = valid_q[wr_idx_i];
  assign wr_old_tag_o   = tag_q[wr_idx_i];
  assign wr_old_ctr_o   = ctr_q[wr_idx_i];

  // Reset wins over a write in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        ctr_q[i]   <= CTR_RESET;
      end
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
      tag_q[wr_idx_i]   <= wr_tag_i;
      ctr_q[wr_idx_i]   <= wr_ctr_i;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped 2-bit BHT predictor with perf counters
//
// Purpose: predicts conditional branches decoded in ID, trains on branches
// resolved in EX, and counts resolved branches and mispredicts.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   bp_enable                      gates pred_taken only
//   guess_pc, guess_is_br          ID lookup request
//   pred_taken, pred_hit           combinational lookup result
//   check_pc, check_is_br,
//   check_taken, check_pred        EX training request
//   br_count, mispred_count        wrapping 32-bit perf counters
module branch_predictor
  import bp_pkg::*;
#(
  parameter  int ENTRIES    = 32,
  localparam int INDEX_BITS = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bp_enable,
  input  logic [31:0] guess_pc,
  input  logic        guess_is_br,
  output logic        pred_taken,
  output logic        pred_hit,
  input  logic [31:0] check_pc,
  input  logic        check_is_br,
  input  logic        check_taken,
  input  logic        check_pred,
  output logic [31:0] br_count,
  output logic [31:0] mispred_count
);

  localparam int TAG_BITS = 30 - INDEX_BITS;

  logic [INDEX_BITS-1:0] guess_idx, check_idx;
  logic [TAG_BITS-1:0]   guess_tag, check_tag;

  assign guess_idx = guess_pc[INDEX_BITS+1:2];
  assign guess_tag = guess_pc[31:INDEX_BITS+2];
  assign check_idx = check_pc[INDEX_BITS+1:2];
  assign check_tag = check_pc[31:INDEX_BITS+2];

  logic                rd_valid, old_valid;
  logic [TAG_BITS-1:0] rd_tag, old_tag;
  ctr_e                rd_ctr, old_ctr, wr_ctr;
  logic                check_hit;

  bht_table #(
    .ENTRIES   (ENTRIES),
    .INDEX_BITS(INDEX_BITS),
    .TAG_BITS  (TAG_BITS)
  ) u_table (
    .clk_i         (clk),
    .rst_i         (rst),
    .rd_idx_i      (guess_idx),
    .rd_valid_o    (rd_valid),
    .rd_tag_o      (rd_tag),
    .rd_ctr_o      (rd_ctr),
    .wr_en_i       (check_is_br),
    .wr_idx_i      (check_idx),
    .wr_tag_i      (check_tag),
    .wr_ctr_i      (wr_ctr),
    .wr_old_valid_o(old_valid),
    .wr_old_tag_o  (old_tag),
    .wr_old_ctr_o  (old_ctr)
  );

  // Lookup reads pre-update state; there is deliberately no write bypass.
  assign pred_hit   = rd_valid & (rd_tag == guess_tag);
  assign pred_taken = bp_enable & guess_is_br & pred_hit & rd_ctr[1];

  // Hit: saturating step. Miss: replace the entry with a weak counter
  // leaning toward the observed outcome.
  assign check_hit = old_valid & (old_tag == check_tag);
  always_comb begin
    wr_ctr = check_taken ? CTR_ALLOC_T : CTR_ALLOC_NT;
    if (check_hit) wr_ctr = ctr_step(old_ctr, check_taken);
  end

  logic [31:0] br_count_q, br_count_d;
  logic [31:0] mispred_count_q, mispred_count_d;

  always_comb begin
    br_count_d      = br_count_q;
    mispred_count_d = mispred_count_q;
    if (check_is_br) begin
      br_count_d = br_count_q + 32'd1;
      if (check_pred != check_taken) mispred_count_d = mispred_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else begin
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign br_count      = br_count_q;
  assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - self-checking bench for branch_predictor
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        bp_enable;
  logic [31:0] guess_pc;
  logic        guess_is_br;
  logic        pred_taken;
  logic        pred_hit;
  logic [31:0] check_pc;
  logic        check_is_br;
  logic        check_taken;
  logic        check_pred;
  logic [31:0] br_count;
  logic [31:0] mispred_count;

  int n_cmp  = 0;
  int n_fail = 0;

  branch_predictor #(.ENTRIES(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .bp_enable    (bp_enable),
    .guess_pc     (guess_pc),
    .guess_is_br  (guess_is_br),
    .pred_taken   (pred_taken),
    .pred_hit     (pred_hit),
    .check_pc     (check_pc),
    .check_is_br  (check_is_br),
    .check_taken  (check_taken),
    .check_pred   (check_pred),
    .br_count     (br_count),
    .mispred_count(mispred_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // 2 units later, well before the next edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic en, input logic [31:0] gpc, input logic gbr,
                       input logic cbr, input logic [31:0] cpc, input logic ct, input logic cp);
    rst = r; bp_enable = en; guess_pc = gpc; guess_is_br = gbr;
    check_is_br = cbr; check_pc = cpc; check_taken = ct; check_pred = cp;
  endtask

  typedef struct {
    logic        en;
    logic [31:0] gpc;
    logic        gbr;
    logic        cbr;
    logic [31:0] cpc;
    logic        ct;
    logic        cp;
    logic        eh;
    logic        et;
    logic [31:0] ebr;
    logic [31:0] emis;
  } vec_t;

  function automatic vec_t mk(input logic en, input logic [31:0] gpc, input logic gbr,
                              input logic cbr, input logic [31:0] cpc, input logic ct,
                              input logic cp, input logic eh, input logic et,
                              input logic [31:0] ebr, input logic [31:0] emis);
    vec_t v;
    v.en = en; v.gpc = gpc; v.gbr = gbr; v.cbr = cbr; v.cpc = cpc; v.ct = ct; v.cp = cp;
    v.eh = eh; v.et = et; v.ebr = ebr; v.emis = emis;
    return v;
  endfunction

  // Reference model: per-index valid/tag and a counter kept as an integer 0..3.
  bit          m_valid [32];
  int unsigned m_tag   [32];
  int          m_ctr   [32];
  logic [31:0] m_br, m_mis;

  function automatic int unsigned idx_of(input logic [31:0] pc);
    return (pc / 4) % 32;
  endfunction
  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc / 128;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_ctr[i] = 1;
    end
    m_br = 0; m_mis = 0;
  endtask

  task automatic model_train(input logic [31:0] pc, input logic t, input logic p);
    int unsigned i;
    i = idx_of(pc);
    if (m_valid[i] && m_tag[i] == tag_of(pc)) begin
      m_ctr[i] = t ? ((m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1)
                   : ((m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1);
    end else begin
      m_valid[i] = 1; m_tag[i] = tag_of(pc); m_ctr[i] = t ? 2 : 1;
    end
    m_br = m_br + 1;
    if (t != p) m_mis = m_mis + 1;
  endtask

  localparam logic [31:0] PA = 32'h4000_0010;
  localparam logic [31:0] PB = 32'h4000_0090;
  localparam logic [31:0] PC = 32'h4000_0020;

  vec_t vecs[$];

  initial begin
    // en gpc gbr | cbr cpc t p | hit taken br mis  (expected before this row's edge)
    vecs.push_back(mk(1, PA, 1, 0, PA, 0, 0, 0, 0,  0, 0));
    vecs.push_back(mk(1, PA, 1, 1, PA, 1, 0, 0, 0,  0, 0));
    vecs.push_back(mk(1, PA, 1, 1, PA, 1, 1, 1, 1,  1, 1));
    vecs.push_back(mk(1, PA, 1, 1, PA, 1, 1, 1, 1,  2, 1));
    vecs.push_back(mk(1, PA, 1, 1, PA, 1, 1, 1, 1,  3, 1));
    vecs.push_back(mk(1, PA, 1, 1, PA, 1, 1, 1, 1,  4, 1));
    vecs.push_back(mk(1, PA, 1, 1, PA, 0, 1, 1, 1,  5, 1));
    vecs.push_back(mk(1, PA, 1, 1, PA, 0, 1, 1, 1,  6, 2));
    vecs.push_back(mk(1, PA, 1, 0, PA, 0, 0, 1, 0,  7, 3));
    vecs.push_back(mk(1, PA, 1, 1, PA, 1, 0, 1, 0,  7, 3));
    vecs.push_back(mk(1, PA, 1, 1, PA, 1, 1, 1, 1,  8, 4));
    vecs.push_back(mk(0, PA, 1, 1, PA, 1, 0, 1, 0,  9, 4));
    vecs.push_back(mk(0, PA, 1, 1, PA, 0, 0, 1, 0, 10, 5));
    vecs.push_back(mk(0, PA, 1, 1, PA, 0, 0, 1, 0, 11, 5));
    vecs.push_back(mk(1, PA, 1, 0, PA, 0, 0, 1, 0, 12, 5));
    vecs.push_back(mk(1, PA, 1, 1, PB, 0, 0, 1, 0, 12, 5));
    vecs.push_back(mk(1, PA, 1, 0, PA, 0, 0, 0, 0, 13, 5));
    vecs.push_back(mk(1, PB, 1, 1, PA, 1, 0, 1, 0, 13, 5));
    vecs.push_back(mk(1, PB, 1, 0, PA, 0, 0, 0, 0, 14, 6));
    vecs.push_back(mk(1, PA, 1, 1, PC, 0, 0, 1, 1, 14, 6));
    vecs.push_back(mk(1, PC, 1, 1, PC, 1, 0, 1, 0, 15, 6));
    vecs.push_back(mk(1, PC, 1, 0, PC, 0, 0, 1, 1, 16, 7));
    vecs.push_back(mk(1, PC | 32'h3, 1, 0, PC, 0, 0, 1, 1, 16, 7));
    vecs.push_back(mk(1, PC, 0, 0, PC, 0, 0, 1, 0, 16, 7));

    drive(1, 1, 0, 0, 0, 0, 0, 0);
    next_cycle();
    for (int i = 0; i < vecs.size(); i++) begin
      drive(0, vecs[i].en, vecs[i].gpc, vecs[i].gbr, vecs[i].cbr, vecs[i].cpc, vecs[i].ct, vecs[i].cp);
      #2;
      chk($sformatf("vec%0d_hit", i), {31'd0, pred_hit}, {31'd0, vecs[i].eh});
      chk($sformatf("vec%0d_taken", i), {31'd0, pred_taken}, {31'd0, vecs[i].et});
      chk($sformatf("vec%0d_br", i), br_count, vecs[i].ebr);
      chk($sformatf("vec%0d_mis", i), mispred_count, vecs[i].emis);
      next_cycle();
    end

    // Reset together with an update of a taken entry: update discarded.
    drive(1, 1, PC, 1, 1, PC, 1, 0);
    next_cycle();
    drive(0, 1, PC, 1, 0, PC, 0, 0);
    #2;
    chk("rst_upd_hit", {31'd0, pred_hit}, 32'd0);
    chk("rst_upd_taken", {31'd0, pred_taken}, 32'd0);
    chk("rst_upd_br", br_count, 32'd0);
    chk("rst_upd_mis", mispred_count, 32'd0);
    next_cycle();
    // The discarded update must not have allocated anything either.
    drive(0, 1, PC, 1, 1, PC, 0, 0);
    #2;
    chk("rst_upd_still_empty", {31'd0, pred_hit}, 32'd0);
    next_cycle();
    drive(0, 1, PC, 1, 0, PC, 0, 0);
    #2;
    chk("alloc_nt_hit", {31'd0, pred_hit}, 32'd1);
    chk("alloc_nt_taken", {31'd0, pred_taken}, 32'd0);
    next_cycle();

    // Randomized phase against the reference model.
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    model_reset();
    next_cycle();
    for (int n = 0; n < 600; n++) begin
      logic r, en, gbr, cbr, ct, cp;
      logic [31:0] gpc, cpc;
      int unsigned gi;
      r   = ($urandom_range(0, 59) == 0);
      en  = ($urandom_range(0, 7) != 0);
      gbr = ($urandom_range(0, 5) != 0);
      cbr = ($urandom_range(0, 3) != 0);
      ct  = $urandom_range(0, 1);
      cp  = $urandom_range(0, 1);
      // Few indices and few tags so hits, saturation and aliasing all occur.
      gpc = 32'h4000_0000 + 128 * $urandom_range(0, 2) + 4 * $urandom_range(0, 3) + $urandom_range(0, 3);
      cpc = 32'h4000_0000 + 128 * $urandom_range(0, 2) + 4 * $urandom_range(0, 3) + $urandom_range(0, 3);
      drive(r, en, gpc, gbr, cbr, cpc, ct, cp);
      #2;
      gi = idx_of(gpc);
      chk($sformatf("rnd%0d_hit", n), {31'd0, pred_hit},
          {31'd0, m_valid[gi] && m_tag[gi] == tag_of(gpc)});
      chk($sformatf("rnd%0d_taken", n), {31'd0, pred_taken},
          {31'd0, en && gbr && m_valid[gi] && m_tag[gi] == tag_of(gpc) && m_ctr[gi] >= 2});
      chk($sformatf("rnd%0d_br", n), br_count, m_br);
      chk($sformatf("rnd%0d_mis", n), mispred_count, m_mis);
      if (r) model_reset();
      else if (cbr) model_train(cpc, ct, cp);
      next_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Direct-mapped branch history table with 2-bit saturating counters that supplies the taken/not-taken guess for conditional branches decoded in ID and is trained by resolved branches from EX. It sits beside the fetch/decode boundary. Its `pred_taken` output drives the ID target selection that redirects fetch, and the EX stage feeds it branch outcomes. The block also keeps branch and mispredict counters for the CSR/MMIO performance registers.

## Interface
- `ENTRIES`, 32: number of table entries; must be a power of two and at least 2.
- `INDEX_BITS`, `$clog2(ENTRIES)`: derived; do not override.
- `clk` in 1: single clock for all state.
- `rst` in 1: reset, synchronous, active-high.
- `bp_enable` in 1: when low, `pred_taken` is forced to 0; training and counters continue.
- `guess_pc` in 32: PC of the instruction currently in ID.
- `guess_is_br` in 1: the ID instruction is a conditional branch.
- `pred_taken` out 1: the prediction for `guess_pc`.
- `pred_hit` out 1: `guess_pc` hits a valid entry with a matching tag.
- `check_pc` in 32: PC of the branch resolved in EX.
- `check_is_br` in 1: the EX instruction is a valid conditional branch (not flushed, not stalled-repeat).
- `check_taken` in 1: actual branch outcome.
- `check_pred` in 1: the prediction that was used for this branch, piped from ID.
- `br_count` out 32: resolved conditional branches since reset.
- `mispred_count` out 32: resolved branches where `check_pred != check_taken`.

## Operation
- Address split:
  - index = `pc[INDEX_BITS+1:2]`.
  - tag = `pc[31:INDEX_BITS+2]`.
  - `pc[1:0]` is ignored.
- Entry contents: valid bit, tag, and 2-bit counter.
  - Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  - Predict taken when the counter MSB is 1.
- Lookup is combinational from the current table state:
  - `pred_hit` = `valid[idx] & (tag[idx] == guess_tag)`.
  - `pred_taken` = `bp_enable & guess_is_br & pred_hit & ctr[idx][1]`.
  - A miss predicts not-taken.
- Update happens on the rising `clk` edge when `check_is_br` = 1:
  - On a hit, the counter increments if `check_taken`, else decrements, saturating at 11 and 00.
  - On a miss, the entry is allocated: valid = 1, tag = `check_tag`, counter = 10 if taken else 01. Replacement is unconditional.
- Performance counters, when `check_is_br` = 1:
  - `br_count` increments by 1.
  - `mispred_count` increments by 1 when `check_pred != check_taken`.
  - Both wrap modulo 2^32.
- `bp_enable` gates only the prediction output. It is never used to qualify updates.

## Timing
- Lookup latency is 0 cycles, a combinational path from `guess_pc` to `pred_taken`. The table is flops, not BRAM.
- Update latency is 1 cycle: a lookup in cycle N+1 sees the update written at the end of cycle N.
- Simultaneous lookup and update to the same index: the lookup returns pre-update state. There is no bypass.
- On reset, in the cycle after `rst` is sampled high:
  - All valid bits are 0 and all counters are 01.
  - `br_count` and `mispred_count` are 0.
  - `pred_taken` and `pred_hit` are 0.
- Reset has priority over a concurrent update; the update is discarded.
- Reset mid-training restores the full reset state in one cycle; no multi-cycle clear.
- Aliasing: two PCs with the same index but different tags evict each other on every update.

## Structure
- The shared package `bp_pkg` holds:
  - Counter encodings `CTR_SNT`, `CTR_WNT`, `CTR_WT`, `CTR_ST`.
  - The reset counter value `CTR_WNT`.
  - The allocation values for taken and not-taken.
- The sub-module `bht_table` holds the valid, tag and counter arrays. It has:
  - One combinational read port.
  - One synchronous write port.
  - Synchronous reset.
- The saturating-update logic and the perf counters live in `branch_predictor`.

## Test plan
- Reset then lookup at `guess_pc` = 0x4000_0010 with `guess_is_br` = 1 -> `pred_hit` = 0, `pred_taken` = 0; `br_count` = `mispred_count` = 0.
- Allocation on a miss:
  - Stimulus: train `check_pc` = 0x4000_0010 taken, `check_pred` = 0.
  - Next cycle: lookup -> hit, `pred_taken` = 1; `br_count` = 1, `mispred_count` = 1.
- Saturation:
  - Train the same PC taken 4 more times, then not-taken once -> `pred_taken` stays 1 (counter 11 -> 10).
  - A second not-taken -> `pred_taken` = 0.
- Aliasing with `ENTRIES` = 32:
  - Train 0x4000_0010 taken, then 0x4000_0090 (same index 4) not-taken.
  - Lookup 0x4000_0010 -> `pred_hit` = 0, `pred_taken` = 0.
- `bp_enable` = 0 with a strongly-taken entry -> `pred_taken` = 0, `pred_hit` = 1; training still changes counters and increments `br_count`.
- Simultaneous lookup and update:
  - Stimulus: lookup and update of 0x4000_0020 in the same cycle (entry weak-NT, update taken).
  - Same cycle: `pred_taken` = 0. Next cycle: `pred_taken` = 1.
  - Asserting `rst` together with an update -> table cleared and the update ignored.
